pipe_flow_ctrl: RTL and testbench
=================================

Name: pipe_flow_ctrl

Overview:
- Flow controller for a fixed-latency delayN chain of depth DEPTH, where each stage captures its input only when ce is high.
- Generates the chain's shared ce and tracks a valid bit per stage.
- Captures chain output into a 2-entry output buffer so downstream backpressure stalls the chain without losing data.
- Converts an always-advancing delay chain into a valid/ready streaming stage.

Parameters:
DEPTH, 3, stages in the controlled delay chain; legal 1..8; must match the external delayN instance.
WID, 8, data width of the chain output and of the output buffer.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active low
en  input  1  global enable; low freezes chain advance and input acceptance
flush  input  1  synchronous clear of all stage valids and the output buffer
in_valid  input  1  upstream offers a word (data goes directly to the chain input, not through this block)
in_ready  output  1  upstream word accepted this cycle when in_valid&in_ready
pipe_ce  output  1  clock enable to the external delay chain
pipe_o  input  WID  chain tail output (stage DEPTH register)
out_valid  output  1  output buffer head valid
out_data  output  WID  output buffer head data
out_ready  input  1  downstream consumes head when out_valid&out_ready
occ  output  4  words in flight: valid stages + buffer entries, 0..DEPTH+2

Behaviour:
- Reset (rst_n low, async): stage valids v[1..DEPTH]=0, buffer empty, out_valid=0, out_data=0, occ=0. pipe_ce and in_ready follow their combinational definitions, which evaluate to en during reset.
- full = buffer count==2.
- pipe_ce = en & ~flush & ~(v[DEPTH] & full). No combinational path from out_ready or in_valid to pipe_ce.
- in_ready = pipe_ce. A bubble (in_valid=0) still advances when pipe_ce=1.
- On edge with pipe_ce=1: v[1]<=in_valid, v[k]<=v[k-1] for k=2..DEPTH. If v[DEPTH]=1, pipe_o is pushed into the buffer on that edge.
- On edge with pipe_ce=0: v unchanged; no push.
- Pop on edge when out_valid&out_ready. Push and pop on the same edge is legal at any count, including count=2. Count is unchanged in that case.
- A stall decision uses the registered full. Full with a simultaneous pop still stalls one cycle; this is accepted as the cost of a register-only ce path.
- Buffer: 2-entry FIFO with 1-bit rd/wr pointers and a 2-bit count. out_data = head entry, registered storage, valid the cycle after the push edge.
- Latency: a word accepted at edge t with no stalls has out_valid=1 in the cycle after edge t+DEPTH, i.e. DEPTH+1 cycles.
- Throughput: 1 word/cycle while out_ready=1.
- en=0: pipe_ce=0, in_ready=0. Pops still occur, so the buffer drains.
- flush=1 (priority over everything except rst_n): next edge v=0, buffer count=0, pointers=0, out_valid=0. No push or pop on that edge. pipe_ce=0 during flush.
- Reset mid-operation: all in-flight words are discarded immediately. The external chain's data regs are not cleared, but their v=0 marks them dead.
- occ = popcount(v) + count, registered, updated every edge.

Optional Feature:
- Macro PIPE_FLOW_STATS_EN.
- When defined, adds outputs stall_cnt[15:0] and xfer_cnt[15:0], both reset to 0 and cleared by flush.
  - stall_cnt increments on each edge where en=1, flush=0 and pipe_ce=0.
  - xfer_cnt increments on each pop.
  - Both saturate at 16'hFFFF.
- When undefined, the ports and logic are absent and the block behaves identically otherwise.

Test Plan:
- DEPTH=3, out_ready=1, in_valid=1 for 5 cycles with chain data 1..5 -> first out_valid 4 cycles after first accept; out_data 1,2,3,4,5 on consecutive cycles; occ peaks at 4.
- out_ready=0, stream 10 words -> exactly 5 accepted (3 stages + 2 buffer); pipe_ce/in_ready=0 thereafter; occ=5. Then out_ready=1 -> remaining words delivered in order with no loss or duplication.
- Buffer full, v[DEPTH]=1, out_ready pulses 1 cycle -> one pop, pipe_ce stays 0 for that cycle, rises the next; count returns to 2.
- Alternating in_valid 1,0,1,0 -> bubbles advance (pipe_ce=1); out_valid alternates 1,0 after DEPTH+1 cycles.
- flush with occ=4 -> next cycle occ=0, out_valid=0; the following accepted word emerges with normal DEPTH+1 latency.
- rst_n low asynchronously mid-stream -> out_valid=0 and occ=0 before the next clk edge. With PIPE_FLOW_STATS_EN, 7 forced stall cycles -> stall_cnt=7.

Source files
------------

// File: rtl/pipe_flow_ctrl.sv
// Valid/ready flow controller for an external DEPTH-stage clock-enabled delay chain.
// Optional PIPE_FLOW_STATS_EN adds saturating stall and transfer counters.
module pipe_flow_ctrl #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WID   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           pipe_ce,
    input  logic [WID-1:0] pipe_o,
    output logic           out_valid,
    output logic [WID-1:0] out_data,
    input  logic           out_ready,
`ifdef PIPE_FLOW_STATS_EN
    output logic [15:0]    stall_cnt,
    output logic [15:0]    xfer_cnt,
`endif
    output logic [3:0]     occ
);

    // v_q[k-1] is the valid bit of chain stage k; v_q[DEPTH-1] tags pipe_o.
    logic [DEPTH-1:0] v_q, v_d;
    logic [WID-1:0]   mem_q [2];
    logic [WID-1:0]   mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [3:0]       occ_q, occ_d;

    logic full;
    logic tail_v;
    logic push;
    logic pop;

    function automatic logic [3:0] popcnt(input logic [DEPTH-1:0] bits);
        logic [3:0] sum;
        sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sum = sum + {3'b000, bits[i]};
        end
        return sum;
    endfunction

    assign full      = (cnt_q == 2'd2);
    assign tail_v    = v_q[DEPTH-1];
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign occ       = occ_q;

    // Stall decision uses only registered state so out_ready never reaches pipe_ce.
    assign pipe_ce  = en & ~flush & ~(tail_v & full);
    assign in_ready = pipe_ce;

    assign push = pipe_ce & tail_v;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        v_d = v_q;
        if (flush) begin
            v_d = '0;
        end else if (pipe_ce) begin
            v_d[0] = in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k] = v_q[k-1];
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = pipe_o;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_comb begin
        occ_d = popcnt(v_d) + {2'b00, cnt_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            occ_q    <= 4'd0;
        end else begin
            v_q      <= v_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            occ_q    <= occ_d;
        end
    end

`ifdef PIPE_FLOW_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
            xfer_cnt_d  = '0;
        end else begin
            if (en && !pipe_ce && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (pop && (xfer_cnt_q != 16'hFFFF)) begin
                xfer_cnt_d = xfer_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign xfer_cnt  = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Scoreboard bench for pipe_flow_ctrl driving a behavioural delay chain; words accepted
// upstream are queued and must leave in order, and occ must equal the words in flight.
module tb_pipe_flow_ctrl;
    localparam int DEPTH = 3;
    localparam int WID   = 8;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           en        = 1'b0;
    logic           flush     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b0;
    logic [WID-1:0] din       = '0;
    logic           in_ready;
    logic           pipe_ce;
    logic           out_valid;
    logic [WID-1:0] pipe_o;
    logic [WID-1:0] out_data;
    logic [3:0]     occ;
`ifdef PIPE_FLOW_STATS_EN
    logic [15:0]    stall_cnt;
    logic [15:0]    xfer_cnt;
`endif

    pipe_flow_ctrl #(.DEPTH(DEPTH), .WID(WID)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pipe_ce   (pipe_ce),
        .pipe_o    (pipe_o),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef PIPE_FLOW_STATS_EN
        .stall_cnt (stall_cnt),
        .xfer_cnt  (xfer_cnt),
`endif
        .occ       (occ)
    );

    always #5 clk = ~clk;

    // External delay chain: data registers only, never cleared.
    logic [WID-1:0] chain [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (pipe_ce) begin
            chain[0] <= din;
            for (int k = 1; k < DEPTH; k++) chain[k] <= chain[k-1];
        end
    end
    assign pipe_o = chain[DEPTH-1];

    logic [WID-1:0] exp_q [$];
    int total = 0, bad = 0;
    int cyc = 0, acc_cnt = 0, pop_cnt = 0, xfer_model = 0;
    int first_acc = -1, first_ov = -1, first_pop = -1, last_pop = -1, max_occ = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Issue side: every accepted word becomes an expected output.
    always @(posedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(din);
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
        end
    end

    // Output monitor: each handshake must deliver the oldest outstanding word.
    always @(posedge clk) begin
        if (!rst_n || flush) begin
            xfer_model = 0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("out_data", int'(out_data), int'(exp_q.pop_front()));
            pop_cnt++;
            xfer_model++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_occ", int'(occ), 0);
            chk("rst_out_valid", int'(out_valid), 0);
        end else begin
            chk("occ_in_flight", int'(occ), exp_q.size());
            if (occ < 3) chk("ready_free", int'(in_ready), int'(en && !flush));
            else if (occ == DEPTH + 2) chk("ready_full", int'(in_ready), 0);
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (int'(occ) > max_occ) max_occ = int'(occ);
`ifdef PIPE_FLOW_STATS_EN
            chk("xfer_cnt", int'(xfer_cnt), xfer_model);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        en        = 1'b1;
        guard     = 0;
        while ((exp_q.size() != 0 || occ != 0) && guard < 60) begin
            step();
            guard++;
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        exp_q.delete();
        en        = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_occ", int'(occ), 0);
        chk("reset_in_ready_en", int'(in_ready), 1);
        chk("reset_pipe_ce_en", int'(pipe_ce), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int w, prev, guard, p0, a0;
        int iv [12];
        int ov [12];

        do_reset();

        // Five back-to-back words, no backpressure.
        out_ready = 1'b1;
        first_acc = -1; first_ov = -1; first_pop = -1; max_occ = 0;
        p0 = pop_cnt;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            din      = WID'(k);
            step();
        end
        in_valid = 1'b0;
        repeat (8) step();
        chk("latency_first", first_ov - first_acc, DEPTH + 1);
        chk("occ_peak", max_occ, 4);
        chk("pops_burst", pop_cnt - p0, 5);
        chk("pop_span", last_pop - first_pop, 4);

        // Backpressure: only DEPTH+2 words fit, then in-order drain.
        out_ready = 1'b0;
        w  = 0;
        a0 = acc_cnt;
        p0 = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            din      = WID'(100 + w);
            prev     = acc_cnt;
            step();
            if (acc_cnt != prev) w++;
        end
        chk("accepted_when_blocked", acc_cnt - a0, DEPTH + 2);
        chk("occ_blocked", int'(occ), DEPTH + 2);
        chk("ready_blocked", int'(in_ready), 0);
        out_ready = 1'b1;
        guard = 0;
        while (w < 10 && guard < 100) begin
            din  = WID'(100 + w);
            prev = acc_cnt;
            step();
            if (acc_cnt != prev) w++;
            guard++;
        end
        chk("accepted_total", acc_cnt - a0, 10);
        drain();
        chk("delivered_total", pop_cnt - p0, 10);

        // Single-cycle out_ready pulse while full: stall persists one cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        guard     = 0;
        while (occ != DEPTH + 2 && guard < 20) begin
            din = WID'($urandom);
            step();
            guard++;
        end
        chk("fill_occ", int'(occ), DEPTH + 2);
        out_ready = 1'b1;
        #1;
        chk("pulse_ready", int'(in_ready), 0);
        step();
        out_ready = 1'b0;
        chk("after_pulse_ready", int'(in_ready), 1);
        chk("after_pulse_occ", int'(occ), DEPTH + 1);
        din = WID'($urandom);
        step();
        chk("refill_occ", int'(occ), DEPTH + 2);
        chk("refill_ready", int'(in_ready), 0);
        drain();

        // Alternating bubbles advance the chain.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i % 2 == 0);
            din      = WID'($urandom);
            iv[i]    = int'(in_valid);
            chk("ready_bubble", int'(in_ready), 1);
            step();
            ov[i] = int'(out_valid);
        end
        for (int i = 0; i < 12; i++) begin
            chk("bubble_out_valid", ov[i], (i >= DEPTH) ? iv[i-DEPTH] : 0);
        end
        drain();

        // Flush with four words in flight, then normal latency.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            din      = WID'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("occ_before_flush", int'(occ), 4);
        flush = 1'b1;
        #1;
        chk("pipe_ce_in_flush", int'(pipe_ce), 0);
        step();
        flush = 1'b0;
        chk("occ_after_flush", int'(occ), 0);
        chk("out_valid_after_flush", int'(out_valid), 0);
        first_acc = -1; first_ov = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din       = 8'h5A;
        step();
        in_valid = 1'b0;
        repeat (DEPTH + 3) step();
        chk("latency_after_flush", first_ov - first_acc, DEPTH + 1);
        drain();

        // Asynchronous reset in mid-stream.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            din = WID'($urandom);
            step();
        end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_occ", int'(occ), 0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

`ifdef PIPE_FLOW_STATS_EN
        flush = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        guard     = 0;
        while (occ != DEPTH + 2 && guard < 20) begin
            din = WID'($urandom);
            step();
            guard++;
        end
        repeat (7) step();
        chk("stall_cnt", int'(stall_cnt), 7);
        drain();
`endif

        // Randomised traffic with enable gaps, flushes and backpressure phases.
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom % 8) != 0;
            flush     = ($urandom % 100) == 0;
            in_valid  = ($urandom % 3) != 0;
            din       = WID'($urandom);
            out_ready = ((i / 300) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
